// File: rtl/pl_col_pkg.sv
// Shared types and constants for the PL column readback initiator.
//   state_t     : reader FSM states
//   PL_COL_PARK : select value driven while idle (no column selected)
//   PL_COL_OR   : broadcast select; every column ORs its word onto the chain
package pl_col_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    OUT   = 2'd2
  } state_t;

  localparam logic [9:0]  PL_COL_PARK = 10'h3FF;
  localparam logic [9:0]  PL_COL_OR   = 10'h000;

  localparam int unsigned DATA_W_DEF  = 36;
  localparam int unsigned COL_W_DEF   = 10;

endpackage

// File: rtl/pl_settle_cnt.sv
// Loadable down-counter timing chain settling after a column select change.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : load SETTLE_CYC (has priority over dec)
//   dec        : decrement, saturating at zero
//   zero       : count is zero (combinational decode of the register)
module pl_settle_cnt #(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int unsigned CW = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(SETTLE_CYC);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pl_col_reader.sv
// Initiator at the end of a column readback chain. Drives the PL column
// select, waits for the chain to settle, captures the chain output and
// returns it over a valid/ready stream. A request reads NUM consecutive
// columns starting at FIRST, or one wired-OR broadcast word (select 0).
//   CLK_i, RST_N_i          : clock, synchronous active-low reset
//   REQ_VALID_i/REQ_READY_o : request handshake (ready only when idle)
//   REQ_FIRST_COL_i, REQ_NUM_i, REQ_OR_MODE_i : request fields
//   PL_COL_o                : column select onto the chain (park when idle)
//   CHAIN_DATA_i            : chain output from the last column
//   RD_VALID_o/RD_READY_i   : read word handshake
//   RD_DATA_o, RD_COL_o, RD_LAST_o : captured word, its column, last flag
//   BUSY_o                  : request in progress
//   ERR_o                   : one-cycle pulse on a rejected request
module pl_col_reader
  import pl_col_pkg::*;
#(
  parameter int unsigned NUM_COLS   = 8,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned COL_W      = COL_W_DEF
) (
  input  logic              CLK_i,
  input  logic              RST_N_i,
  input  logic              REQ_VALID_i,
  output logic              REQ_READY_o,
  input  logic [COL_W-1:0]  REQ_FIRST_COL_i,
  input  logic [COL_W-1:0]  REQ_NUM_i,
  input  logic              REQ_OR_MODE_i,
  output logic [COL_W-1:0]  PL_COL_o,
  input  logic [DATA_W-1:0] CHAIN_DATA_i,
  output logic              RD_VALID_o,
  input  logic              RD_READY_i,
  output logic [DATA_W-1:0] RD_DATA_o,
  output logic [COL_W-1:0]  RD_COL_o,
  output logic              RD_LAST_o,
  output logic              BUSY_o,
  output logic              ERR_o
);

  state_t           state;
  logic [COL_W-1:0] remaining;

  logic [COL_W:0]   first_x;
  logic [COL_W:0]   num_x;
  logic [COL_W:0]   last_x;
  logic             req_bad;
  logic             req_fire;
  logic             rd_hs;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;

  // One extra bit so FIRST+NUM-1 cannot wrap back into the legal range.
  assign first_x = {1'b0, REQ_FIRST_COL_i};
  assign num_x   = {1'b0, REQ_NUM_i};
  assign last_x  = first_x + num_x - (COL_W+1)'(1);

  assign req_bad = (REQ_FIRST_COL_i == '0) || (REQ_NUM_i == '0) ||
                   (first_x > (COL_W+1)'(NUM_COLS)) ||
                   (last_x  > (COL_W+1)'(NUM_COLS));

  assign req_fire = REQ_VALID_i && (state == IDLE);
  // RD_VALID_o is high for the whole of OUT, so ready alone completes it.
  assign rd_hs    = (state == OUT) && RD_READY_i;

  assign cnt_load = (req_fire && (REQ_OR_MODE_i || !req_bad)) ||
                    (rd_hs && !RD_LAST_o);
  assign cnt_dec  = (state == DRIVE) && !cnt_zero;

  pl_settle_cnt #(
    .SETTLE_CYC(SETTLE_CYC)
  ) u_settle (
    .clk  (CLK_i),
    .rst_n(RST_N_i),
    .load (cnt_load),
    .dec  (cnt_dec),
    .zero (cnt_zero)
  );

  always_ff @(posedge CLK_i) begin
    if (!RST_N_i) begin
      state      <= IDLE;
      PL_COL_o   <= COL_W'(PL_COL_PARK);
      remaining  <= '0;
      RD_VALID_o <= 1'b0;
      RD_DATA_o  <= '0;
      RD_COL_o   <= '0;
      RD_LAST_o  <= 1'b0;
      ERR_o      <= 1'b0;
    end else begin
      ERR_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (REQ_VALID_i) begin
            if (REQ_OR_MODE_i) begin
              PL_COL_o  <= COL_W'(PL_COL_OR);
              remaining <= COL_W'(1);
              state     <= DRIVE;
            end else if (req_bad) begin
              ERR_o <= 1'b1;
            end else begin
              PL_COL_o  <= REQ_FIRST_COL_i;
              remaining <= REQ_NUM_i;
              state     <= DRIVE;
            end
          end
        end
        DRIVE: begin
          if (cnt_zero) begin
            RD_DATA_o  <= CHAIN_DATA_i;
            RD_COL_o   <= PL_COL_o;
            RD_LAST_o  <= (remaining == COL_W'(1));
            RD_VALID_o <= 1'b1;
            state      <= OUT;
          end
        end
        OUT: begin
          if (RD_READY_i) begin
            RD_VALID_o <= 1'b0;
            if (RD_LAST_o) begin
              PL_COL_o <= COL_W'(PL_COL_PARK);
              state    <= IDLE;
            end else begin
              PL_COL_o  <= PL_COL_o + COL_W'(1);
              remaining <= remaining - COL_W'(1);
              state     <= DRIVE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign BUSY_o      = (state != IDLE);
  assign REQ_READY_o = (state == IDLE);

endmodule

// File: tb/tb_pl_col_reader.sv
`timescale 1ns/1ps
module tb_pl_col_reader;

  localparam int NC = 8;
  localparam int S  = 2;

  typedef struct {
    logic [35:0] data;
    logic [9:0]  col;
    logic        last;
    int          gap;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance (SETTLE_CYC=2)
  logic        req_valid = 1'b0, req_ready, req_or = 1'b0;
  logic [9:0]  req_first = '0, req_num = '0, pl_col, rd_col;
  logic [35:0] chain_data, rd_data, chain_comb;
  logic        rd_valid, rd_ready = 1'b1, rd_last, busy, err;

  // Zero-settle instance
  logic        req_valid0 = 1'b0, req_ready0;
  logic [9:0]  req_first0 = '0, req_num0 = '0, pl_col0, rd_col0;
  logic [35:0] chain0, rd_data0;
  logic        rd_valid0, rd_ready0 = 1'b1, rd_last0, busy0, err0;

  logic [35:0] col_data [1:NC];
  logic [35:0] pipe [0:S-1];

  pl_col_reader #(.NUM_COLS(NC), .SETTLE_CYC(S), .DATA_W(36), .COL_W(10)) u_dut (
    .CLK_i(clk), .RST_N_i(rst_n), .REQ_VALID_i(req_valid), .REQ_READY_o(req_ready),
    .REQ_FIRST_COL_i(req_first), .REQ_NUM_i(req_num), .REQ_OR_MODE_i(req_or),
    .PL_COL_o(pl_col), .CHAIN_DATA_i(chain_data), .RD_VALID_o(rd_valid),
    .RD_READY_i(rd_ready), .RD_DATA_o(rd_data), .RD_COL_o(rd_col),
    .RD_LAST_o(rd_last), .BUSY_o(busy), .ERR_o(err));

  pl_col_reader #(.NUM_COLS(NC), .SETTLE_CYC(0), .DATA_W(36), .COL_W(10)) u_dut0 (
    .CLK_i(clk), .RST_N_i(rst_n), .REQ_VALID_i(req_valid0), .REQ_READY_o(req_ready0),
    .REQ_FIRST_COL_i(req_first0), .REQ_NUM_i(req_num0), .REQ_OR_MODE_i(1'b0),
    .PL_COL_o(pl_col0), .CHAIN_DATA_i(chain0), .RD_VALID_o(rd_valid0),
    .RD_READY_i(rd_ready0), .RD_DATA_o(rd_data0), .RD_COL_o(rd_col0),
    .RD_LAST_o(rd_last0), .BUSY_o(busy0), .ERR_o(err0));

  // Behavioural chain: each stage passes upstream data unless selected;
  // select 0 makes every stage OR its word in.
  always_comb begin
    chain_comb = '0;
    for (int k = 1; k <= NC; k++) begin
      if (pl_col == '0) chain_comb = chain_comb | col_data[k];
      else if (pl_col == 10'(k)) chain_comb = col_data[k];
    end
  end

  always_comb begin
    chain0 = '0;
    for (int k = 1; k <= NC; k++) begin
      if (pl_col0 == '0) chain0 = chain0 | col_data[k];
      else if (pl_col0 == 10'(k)) chain0 = col_data[k];
    end
  end

  // Settling delay: a select change is only visible S cycles later.
  always_ff @(posedge clk) begin
    pipe[0] <= chain_comb;
    for (int i = 1; i < S; i++) pipe[i] <= pipe[i-1];
  end
  assign chain_data = pipe[S-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [35:0] d, input logic [9:0] c, input logic l, input int g);
    exp_t e;
    e.data = d; e.col = c; e.last = l; e.gap = g;
    q.push_back(e);
  endtask

  task automatic issue(input logic [9:0] first, input logic [9:0] num, input logic orm);
    req_valid = 1'b1; req_first = first; req_num = num; req_or = orm;
    tick;
    req_valid = 1'b0; req_or = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while (busy && n < max) begin
      tick;
      n++;
    end
    chk({name, "_idle"}, busy, 0);
  endtask

  // Monitor / scoreboard
  initial begin : monitor
    int cyc = 0;
    int last_hs = 0;
    logic stalled = 1'b0;
    logic [35:0] pd;
    logic [9:0]  pc;
    logic        pl;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (rd_valid) chk("valid_only_busy", busy, 1);
        if (stalled) begin
          chk("stall_valid_held", rd_valid, 1);
          chk("stall_data", rd_data, pd);
          chk("stall_col", rd_col, pc);
          chk("stall_last", rd_last, pl);
        end
        if (rd_valid && rd_ready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got col %0h data %0h expected none", rd_col, rd_data);
          end else begin
            e = q.pop_front();
            chk("rd_data", rd_data, e.data);
            chk("rd_col", rd_col, e.col);
            chk("rd_last", rd_last, e.last);
            if (e.gap != 0) chk("word_gap", cyc - last_hs, e.gap);
          end
          last_hs = cyc;
        end
        stalled = rd_valid && !rd_ready;
        pd = rd_data; pc = rd_col; pl = rd_last;
      end
    end
  end

  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin : stim
    int n;
    for (int k = 1; k <= NC; k++) col_data[k] = 36'(32'hC0 | k);

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick;
    chk("rst_pl_col", pl_col, 10'h3FF);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_col", rd_col, 0);
    chk("rst_rd_last", rd_last, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 1);
    rst_n = 1'b1;
    tick;

    // Single column: accept at T, valid at T+4
    push(36'h0C3, 10'd3, 1'b1, 0);
    issue(10'd3, 10'd1, 1'b0);
    chk("t1_pl_col", pl_col, 3);
    chk("t1_busy", busy, 1);
    chk("t1_req_ready", req_ready, 0);
    tick; chk("t1_valid_t2", rd_valid, 0);
    tick; chk("t1_valid_t3", rd_valid, 0);
    tick; chk("t1_valid_t4", rd_valid, 1);
    tick;
    chk("t1_req_ready_after", req_ready, 1);
    chk("t1_valid_after", rd_valid, 0);
    chk("t1_park", pl_col, 10'h3FF);

    // Multi-column sweep
    push(36'h0C2, 10'd2, 1'b0, 0);
    push(36'h0C3, 10'd3, 1'b0, 4);
    push(36'h0C4, 10'd4, 1'b0, 4);
    push(36'h0C5, 10'd5, 1'b1, 4);
    issue(10'd2, 10'd4, 1'b0);
    wait_idle("sweep", 100);
    chk("sweep_park", pl_col, 10'h3FF);

    // OR broadcast
    for (int k = 1; k <= NC; k++) col_data[k] = 36'(1) << k;
    repeat (3) tick;
    push(36'h1FE, 10'd0, 1'b1, 0);
    issue(10'd0, 10'd0, 1'b1);
    chk("or_pl_col", pl_col, 0);
    wait_idle("or", 50);
    for (int k = 1; k <= NC; k++) col_data[k] = 36'(32'hC0 | k);
    repeat (3) tick;

    // Backpressure on first word
    rd_ready = 1'b0;
    push(36'h0C1, 10'd1, 1'b0, 0);
    push(36'h0C2, 10'd2, 1'b1, 0);
    issue(10'd1, 10'd2, 1'b0);
    n = 0;
    while (!rd_valid && n < 20) begin tick; n++; end
    chk("bp_valid_seen", rd_valid, 1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_pl_col_hold", pl_col, 1);
      tick;
    end
    rd_ready = 1'b1;
    tick;
    chk("bp_next_col", pl_col, 2);
    chk("bp_valid_drop", rd_valid, 0);
    wait_idle("bp", 50);

    // Rejects, including a sum that would wrap in COL_W bits
    begin
      logic [9:0] rf [5];
      logic [9:0] rn [5];
      rf[0] = 10'd0; rn[0] = 10'd2;
      rf[1] = 10'd7; rn[1] = 10'd3;
      rf[2] = 10'd3; rn[2] = 10'd0;
      rf[3] = 10'd9; rn[3] = 10'd1;
      rf[4] = 10'd2; rn[4] = 10'h3FF;
      for (int i = 0; i < 5; i++) begin
        issue(rf[i], rn[i], 1'b0);
        chk("rej_err", err, 1);
        chk("rej_busy", busy, 0);
        chk("rej_valid", rd_valid, 0);
        chk("rej_pl_col", pl_col, 10'h3FF);
        tick;
        chk("rej_err_pulse", err, 0);
        chk("rej_req_ready", req_ready, 1);
      end
    end

    // Last column is a legal selection
    push(36'h0C8, 10'd8, 1'b1, 0);
    issue(10'd8, 10'd1, 1'b0);
    wait_idle("lastcol", 50);

    // Reset during DRIVE abandons the request
    issue(10'd1, 10'd4, 1'b0);
    tick;
    rst_n = 1'b0;
    tick;
    chk("mrst_pl_col", pl_col, 10'h3FF);
    chk("mrst_valid", rd_valid, 0);
    chk("mrst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (3) tick;
    push(36'h0C6, 10'd6, 1'b0, 0);
    push(36'h0C7, 10'd7, 1'b1, 4);
    issue(10'd6, 10'd2, 1'b0);
    wait_idle("post_rst", 50);

    // Zero settle: valid at T+2
    req_valid0 = 1'b1; req_first0 = 10'd4; req_num0 = 10'd1;
    tick;
    req_valid0 = 1'b0;
    chk("s0_pl_col", pl_col0, 4);
    chk("s0_valid_t1", rd_valid0, 0);
    tick;
    chk("s0_valid_t2", rd_valid0, 1);
    chk("s0_data", rd_data0, 36'h0C4);
    chk("s0_col", rd_col0, 4);
    chk("s0_last", rd_last0, 1);
    tick;
    chk("s0_busy_after", busy0, 0);
    chk("s0_park", pl_col0, 10'h3FF);

    repeat (3) tick;
    chk("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pl_col_reader.md
Name: pl_col_reader

Overview:
- Initiator end of the column readback chain: drives the chain's PL column select and captures the 36-bit word at the last column's chain output.
- Each request reads 1..N consecutive columns, or one wired-OR broadcast read (select 0).
- Returns captured words over a valid/ready stream to the configuration readback logic.
- Sits at the chain end, one instance per chain.

Parameters:
- NUM_COLS, 8, number of columns; valid column IDs are 1..NUM_COLS.
- SETTLE_CYC, 2, cycles of combinational chain settling after PL_COL_o changes, before sampling (0 legal).
- DATA_W, 36, chain data width.
- COL_W, 10, column ID width.

Ports:
- CLK_i  in  1  clock
- RST_N_i  in  1  synchronous active-low reset
- REQ_VALID_i  in  1  request valid
- REQ_READY_o  out  1  request accepted when VALID&READY
- REQ_FIRST_COL_i  in  COL_W  first column ID
- REQ_NUM_i  in  COL_W  number of columns to read
- REQ_OR_MODE_i  in  1  1 = single broadcast read with select 0; FIRST/NUM ignored
- PL_COL_o  out  COL_W  column select driven onto the chain
- CHAIN_DATA_i  in  DATA_W  chain output from the last column
- RD_VALID_o  out  1  read word valid
- RD_READY_i  in  1  consumer ready
- RD_DATA_o  out  DATA_W  captured word
- RD_COL_o  out  COL_W  column ID of the word (0 in OR mode)
- RD_LAST_o  out  1  final word of the request
- BUSY_o  out  1  state != IDLE
- ERR_o  out  1  one-cycle pulse on rejected request

Behaviour:
- Reset: state IDLE, PL_COL_o=10'h3FF (park), RD_VALID_o=0, RD_DATA_o=0, RD_COL_o=0, RD_LAST_o=0, ERR_o=0, BUSY_o=0, REQ_READY_o=1.
- Reset mid-request abandons the request; no word is emitted.
- States:
  - IDLE: REQ_READY_o=1.
  - DRIVE: settle counter running.
  - OUT: RD_VALID_o held.
- REQ_READY_o=1 only in IDLE.
- Request accepted in cycle T:
  - OR mode: PL_COL_o=0, remaining=1.
  - Otherwise: validate. Reject if FIRST==0, NUM==0, FIRST>NUM_COLS, or FIRST+NUM-1>NUM_COLS. Use COL_W+1-bit arithmetic so the sum cannot wrap.
  - Reject: ERR_o=1 at T+1, stay IDLE, PL_COL_o unchanged.
  - Valid: at T+1, PL_COL_o=FIRST, remaining=NUM, state DRIVE, cnt=SETTLE_CYC.
- DRIVE:
  - cnt!=0: decrement.
  - cnt==0: RD_DATA_o<=CHAIN_DATA_i, RD_COL_o<=PL_COL_o, RD_LAST_o<=(remaining==1), go to OUT.
  - First capture is at T+1+SETTLE_CYC; RD_VALID_o rises at T+2+SETTLE_CYC.
- OUT:
  - RD_VALID_o, data, col and last stay stable until RD_READY_i.
  - PL_COL_o holds, so backpressure never changes the selected column.
- Handshake, not last: PL_COL_o+1, remaining-1, cnt=SETTLE_CYC, go to DRIVE; the next valid comes SETTLE_CYC+2 cycles after the handshake.
- Handshake, last: go to IDLE, RD_VALID_o=0, PL_COL_o=10'h3FF, REQ_READY_o=1 the next cycle.
- No back-to-back overlap: a new request cannot be accepted in the cycle of the last handshake.
- Selecting NUM_COLS is legal; the last column always drives its own data.
- RD_VALID_o never asserts in IDLE or DRIVE.
- REQ_VALID_i while busy is ignored; the requester holds it.

Decomposition:
- Package pl_col_pkg:
  - state enum {IDLE, DRIVE, OUT}
  - localparams PL_COL_PARK=10'h3FF and PL_COL_OR=10'h000
  - DATA_W/COL_W defaults
- Sub-module pl_settle_cnt: loadable down-counter with zero flag, sized $clog2(SETTLE_CYC+1), minimum 1 bit.
- Bench model: behavioural chain of NUM_COLS PLMUX-equivalent stages driven by PL_COL_o, with a SETTLE_CYC-deep delay on CHAIN_DATA_i.

Test Plan:
- Single column, one read: SETTLE_CYC=2, column data = 36'h0000000C3, accept FIRST=3, NUM=1 at T=0 → PL_COL_o=3 at T=1, RD_VALID_o=1 at T=4, RD_DATA_o=36'h0000000C3, RD_COL_o=3, RD_LAST_o=1; REQ_READY_o=1 the cycle after the handshake.
- Multi-column sweep: FIRST=2, NUM=4, RD_READY_i=1 → words for cols 2,3,4,5 in order, spaced 4 cycles apart, RD_LAST_o only on col 5, PL_COL_o=10'h3FF afterwards.
- OR mode: column k data = 1<<k for k=1..8, REQ_OR_MODE_i=1 → PL_COL_o=0, one word 36'h1FE, RD_COL_o=0, RD_LAST_o=1.
- Backpressure: FIRST=1, NUM=2, RD_READY_i low for 10 cycles on the first word → RD_DATA_o/RD_COL_o stable and PL_COL_o=1 throughout; col 2 issued only after the handshake.
- Rejects: FIRST=0; FIRST=7 with NUM=3 (NUM_COLS=8); NUM=0 → each gives a one-cycle ERR_o, BUSY_o stays 0, no RD_VALID_o.
- Reset mid-operation: RST_N_i low during DRIVE of a 4-column request → next cycle IDLE, PL_COL_o=10'h3FF, RD_VALID_o=0; a new request then completes normally. Also run SETTLE_CYC=0: valid at T+2.
